// File: rtl/axi4l_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite master arbiter.
package axi4l_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4l_req_arb_if.sv
// AXI4-Lite bus bundle; master modport faces the arbiter, slave modport the memory side.
interface axi4l_req_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_awaddr;
    logic [2:0]          m_awprot;
    logic                m_awvalid;
    logic                m_awready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wvalid;
    logic                m_wready;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;
    logic [ADDR_W-1:0]   m_araddr;
    logic [2:0]          m_arprot;
    logic                m_arvalid;
    logic                m_arready;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rvalid;
    logic                m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/axi4l_req_arb_rr_arb2.sv
// Two-input round-robin picker: one-hot winner plus the pointer value to store if it is taken.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win,
    output logic       last_nxt
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        win      = 2'b00;
        last_nxt = last;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
        if (|win) last_nxt = win[1];
    end

endmodule

// File: rtl/axi4l_req_arb.sv
// Two-requester AXI4-Lite master: round-robin picks one command, issues it, reports completion.
module axi4l_req_arb
    import axi4l_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [2*DATA_W/8-1:0] wstrb,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            resp,
    axi4l_req_arb_if.master       m
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state;
    logic                last;
    logic                last_nxt;
    logic                sel;
    logic [1:0]          win;
    logic                pick;
    logic                pick_we;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;
    logic [STRB_W-1:0]   pick_wstrb;

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last     (last),
        .win      (win),
        .last_nxt (last_nxt)
    );

    assign pick       = win[1];
    assign pick_we    = pick ? we[1] : we[0];
    assign pick_addr  = pick ? addr[ADDR_W +: ADDR_W]  : addr[0 +: ADDR_W];
    assign pick_wdata = pick ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
    assign pick_wstrb = pick ? wstrb[STRB_W +: STRB_W] : wstrb[0 +: STRB_W];

    assign m.m_awprot = PROT_DEFAULT;
    assign m.m_arprot = PROT_DEFAULT;

    // NOTE: datapath registers are reset along with control so the bus never shows X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            sel         <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            resp        <= OKAY;
            m.m_awaddr  <= '0;
            m.m_awvalid <= 1'b0;
            m.m_wdata   <= '0;
            m.m_wstrb   <= '0;
            m.m_wvalid  <= 1'b0;
            m.m_bready  <= 1'b0;
            m.m_araddr  <= '0;
            m.m_arvalid <= 1'b0;
            m.m_rready  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            gnt  <= '0;
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        sel  <= pick;
                        last <= last_nxt;
                        gnt  <= win;
                        if (pick_we) begin
                            state       <= WRITE;
                            m.m_awaddr  <= pick_addr;
                            m.m_wdata   <= pick_wdata;
                            m.m_wstrb   <= pick_wstrb;
                            m.m_awvalid <= 1'b1;
                            m.m_wvalid  <= 1'b1;
                            m.m_bready  <= 1'b1;
                        end else begin
                            state       <= READ;
                            m.m_araddr  <= pick_addr;
                            m.m_arvalid <= 1'b1;
                            m.m_rready  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (m.m_awvalid && m.m_awready) m.m_awvalid <= 1'b0;
                    if (m.m_wvalid && m.m_wready)   m.m_wvalid  <= 1'b0;
                    if (m.m_bvalid && m.m_bready) begin
                        resp        <= m.m_bresp;
                        done        <= sel ? 2'b10 : 2'b01;
                        m.m_awvalid <= 1'b0;
                        m.m_wvalid  <= 1'b0;
                        m.m_bready  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                READ: begin
                    if (m.m_arvalid && m.m_arready) m.m_arvalid <= 1'b0;
                    if (m.m_rvalid && m.m_rready) begin
                        rdata       <= m.m_rdata;
                        resp        <= m.m_rresp;
                        done        <= sel ? 2'b10 : 2'b01;
                        m.m_arvalid <= 1'b0;
                        m.m_rready  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_req_arb.sv
// Directed bench for axi4l_req_arb against a small AXI4-Lite slave memory with skewable W ready.
module tb_axi4l_req_arb;
    import axi4l_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req = '0;
    logic [1:0]      we = '0;
    logic [2*AW-1:0] addr = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [2*SW-1:0] wstrb = '0;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [DW-1:0]   rdata;
    logic [1:0]      resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4l_req_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi4l_req_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .wstrb (wstrb),
        .gnt   (gnt),
        .done  (done),
        .rdata (rdata),
        .resp  (resp),
        .m     (bus)
    );

    // Slave: 16-word window at 32'h44a0_0000; reads elsewhere give SLVERR, writes DECERR.
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [31:0] aw_q, wd_q;
    logic [3:0]  ws_q;
    int          w_wait;
    int          w_delay = 0;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    function automatic logic in_range(input logic [31:0] a);
        return (a & 32'hFFFF_FFC0) == 32'h44A0_0000;
    endfunction

    assign bus.m_awready = 1'b1;
    assign bus.m_arready = 1'b1;
    assign bus.m_wready  = (w_wait >= w_delay);

    always @(posedge clk or negedge rst) begin : slave
        logic        aw_hs, w_hs;
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        if (!rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_q <= '0; wd_q <= '0; ws_q <= '0; w_wait <= 0;
            bus.m_bvalid <= 1'b0; bus.m_bresp <= OKAY;
            bus.m_rvalid <= 1'b0; bus.m_rresp <= OKAY; bus.m_rdata <= '0;
        end else begin
            aw_hs = bus.m_awvalid && bus.m_awready;
            w_hs  = bus.m_wvalid && bus.m_wready;
            wa    = aw_hs ? bus.m_awaddr : aw_q;
            wd    = w_hs ? bus.m_wdata : wd_q;
            ws    = w_hs ? bus.m_wstrb : ws_q;
            if (bd_we) mem[bd_addr[5:2]] <= bd_data;
            if (bus.m_wvalid && !w_hs) w_wait <= w_wait + 1;
            else                       w_wait <= 0;
            if (bus.m_bvalid && bus.m_bready) bus.m_bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (in_range(wa)) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) mem[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
                    bus.m_bresp <= OKAY;
                end else begin
                    bus.m_bresp <= DECERR;
                end
                bus.m_bvalid <= 1'b1;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_q <= bus.m_awaddr; end
                if (w_hs)  begin w_got <= 1'b1; wd_q <= bus.m_wdata; ws_q <= bus.m_wstrb; end
            end
            if (bus.m_rvalid && bus.m_rready) bus.m_rvalid <= 1'b0;
            if (bus.m_arvalid && bus.m_arready) begin
                bus.m_rvalid <= 1'b1;
                bus.m_rdata  <= in_range(bus.m_araddr) ? mem[bus.m_araddr[5:2]] : 32'hDEAD_BEEF;
                bus.m_rresp  <= in_range(bus.m_araddr) ? OKAY : SLVERR;
            end
        end
    end

    int aw_hi = 0;
    int w_hi = 0;
    int done0_cnt = 0;
    always @(negedge clk) begin
        if (bus.m_awvalid) aw_hi <= aw_hi + 1;
        if (bus.m_wvalid)  w_hi  <= w_hi + 1;
        if (done[0])       done0_cnt <= done0_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic backdoor_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Cycle numbers count negedges after the one where req is raised.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rs,
                         output int t_gnt, output int t_done);
        int n;
        rd = '0; rs = '0; t_gnt = -1; t_done = -1; n = 0;
        @(negedge clk);
        we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; wstrb[i*SW +: SW] = s;
        req[i] = 1'b1;
        while (t_gnt < 0 && n < 64) begin
            @(negedge clk); n++;
            if (gnt[i]) t_gnt = n;
        end
        req[i] = 1'b0;
        while (t_gnt >= 0 && t_done < 0 && n < 128) begin
            @(negedge clk); n++;
            if (done[i]) begin t_done = n; rd = rdata; rs = resp; end
        end
        if (t_gnt < 0 || t_done < 0) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: req%0d gnt_cycle=%0d done_cycle=%0d, expected both seen", i, t_gnt, t_done);
        end
    endtask

    function automatic logic [31:0] cont_data(input int i, input int k);
        return 32'hC0DE_0000 | 32'(i << 4) | 32'(k);
    endfunction

    task automatic load_cmd(input int i, input int k);
        we[i] = 1'b1;
        addr[i*AW +: AW]  = 32'h44A0_0010 + 32'(i * 16) + 32'(k * 4);
        wdata[i*DW +: DW] = cont_data(i, k);
        wstrb[i*SW +: SW] = 4'hF;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int tg, td, a0, w0, d0;
        int cnt[2];
        int glog[$], gcyc[$], dlog[$];
        int cyc;

        // Reset state
        #2;
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 3'b000);
        check("rst_readies", {bus.m_bready, bus.m_rready}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", resp, OKAY);
        check("rst_awaddr", bus.m_awaddr, 32'h0);
        check("rst_araddr", bus.m_araddr, 32'h0);
        check("rst_prot", {bus.m_awprot, bus.m_arprot}, 6'b0);

        // Contention: both requesters active out of reset, four writes each
        cnt[0] = 0; cnt[1] = 0; cyc = 0;
        load_cmd(0, 0);
        load_cmd(1, 0);
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 200 && dlog.size() < 8; c++) begin
            @(negedge clk); cyc++;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin glog.push_back(i); gcyc.push_back(cyc); req[i] = 1'b0; end
                if (done[i]) begin
                    dlog.push_back(i);
                    check("cont_resp", resp, OKAY);
                    cnt[i]++;
                    if (cnt[i] < 4) begin load_cmd(i, cnt[i]); req[i] = 1'b1; end
                end
            end
        end
        check("cont_gnt_count", glog.size(), 8);
        check("cont_done_count", dlog.size(), 8);
        for (int k = 0; k < glog.size(); k++) check("cont_order", glog[k], k % 2);
        for (int k = 0; k < dlog.size() && k < glog.size(); k++) check("cont_done_match", dlog[k], glog[k]);
        for (int k = 1; k < gcyc.size(); k++) check("cont_spacing", gcyc[k] - gcyc[k-1], 3);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) check("cont_mem", mem[4 + i*4 + k], cont_data(i, k));

        // Single write with zero-wait latency
        issue(0, 1'b1, 32'h44A0_0000, 32'h1234_5678, 4'hF, rd, rs, tg, td);
        check("wr_gnt_cycle", tg, 1);
        check("wr_done_cycle", td, 3);
        check("wr_resp", rs, OKAY);
        check("wr_mem", mem[0], 32'h1234_5678);

        // Single read from requester 1
        backdoor_write(32'h44A0_0008, 32'hCAFE_F00D);
        issue(1, 1'b0, 32'h44A0_0008, 32'h0, 4'h0, rd, rs, tg, td);
        check("rd_gnt_cycle", tg, 1);
        check("rd_done_cycle", td, 3);
        check("rd_data", rd, 32'hCAFE_F00D);
        check("rd_resp", rs, OKAY);

        // W ready lags AW ready by three cycles
        a0 = aw_hi; w0 = w_hi; d0 = done0_cnt;
        w_delay = 3;
        issue(0, 1'b1, 32'h44A0_000C, 32'h5A5A_A5A5, 4'hF, rd, rs, tg, td);
        @(negedge clk);
        w_delay = 0;
        check("skew_aw_cycles", aw_hi - a0, 1);
        check("skew_w_cycles", w_hi - w0, 4);
        check("skew_done_count", done0_cnt - d0, 1);
        check("skew_done_cycle", td, 6);
        check("skew_mem", mem[3], 32'h5A5A_A5A5);

        // Partial strobe merges into existing word
        backdoor_write(32'h44A0_0004, 32'h1111_1111);
        issue(1, 1'b1, 32'h44A0_0004, 32'hAABB_CCDD, 4'b0011, rd, rs, tg, td);
        check("strb_resp", rs, OKAY);
        check("strb_mem", mem[1], 32'h1111_CCDD);

        // Error responses pass through unchanged
        issue(0, 1'b0, 32'h44A0_0100, 32'h0, 4'h0, rd, rs, tg, td);
        check("err_rd_resp", rs, SLVERR);
        check("err_rd_data", rd, 32'hDEAD_BEEF);
        issue(1, 1'b1, 32'h44A0_0200, 32'h0BAD_0BAD, 4'hF, rd, rs, tg, td);
        check("err_wr_resp", rs, DECERR);

        // Reset while AR is outstanding
        @(negedge clk);
        we[0] = 1'b0; addr[0 +: AW] = 32'h44A0_0008; req[0] = 1'b1;
        @(negedge clk);
        check("rstmid_arvalid_pre", bus.m_arvalid, 1'b1);
        d0 = done0_cnt;
        rst = 1'b0;
        #1;
        check("rstmid_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 3'b000);
        check("rstmid_readies", {bus.m_bready, bus.m_rready}, 2'b00);
        check("rstmid_gnt_done", {gnt, done}, 4'b0000);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_no_done", done0_cnt - d0, 0);
        issue(0, 1'b0, 32'h44A0_0008, 32'h0, 4'h0, rd, rs, tg, td);
        check("rstmid_after_done_cycle", td, 3);
        check("rstmid_after_data", rd, 32'hCAFE_F00D);
        check("rstmid_after_resp", rs, OKAY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4l_req_arb.md
# axi4l_req_arb

Two-requester AXI4-Lite master arbiter. It accepts single-beat read/write commands from two local requesters and issues them, one at a time, on a single AXI4-Lite master port. Round-robin arbitration is used. It sits between on-chip control logic and the AXI4-Lite slave region at 32'h44a0_0000, and is verified against the AXI VIP slave memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester command request; held until gnt
- we  in  2  per-requester direction: 1 = write, 0 = read
- addr  in  2*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  per-requester write data, packed the same way
- wstrb  in  2*DATA_W/8  per-requester byte strobes, packed the same way
- gnt  out  2  one-cycle pulse: command captured
- done  out  2  one-cycle pulse: transaction complete
- rdata  out  DATA_W  read data, valid with done
- resp  out  2  BRESP/RRESP, valid with done
- AW channel: m_awaddr out ADDR_W, m_awprot out 3, m_awvalid out 1, m_awready in 1
- W channel: m_wdata out DATA_W, m_wstrb out DATA_W/8, m_wvalid out 1, m_wready in 1
- B channel: m_bresp in 2, m_bvalid in 1, m_bready out 1
- AR channel: m_araddr out ADDR_W, m_arprot out 3, m_arvalid out 1, m_arready in 1
- R channel: m_rdata in DATA_W, m_rresp in 2, m_rvalid in 1, m_rready out 1

## Operation
- FSM states: IDLE, WRITE, READ.
- **IDLE**
  - If any req is high, pick a winner and capture its we/addr/wdata/wstrb into registers.
  - Go to WRITE if we=1, else READ.
- **Arbitration**
  - Round-robin with a one-bit last-grant pointer. When both requesters are active, the one not granted last wins.
  - A single active requester always wins.
  - The pointer resets to "last = 1", so requester 0 wins the first contention.
- **gnt**
  - gnt[i] pulses for exactly one cycle, on the first cycle of WRITE/READ.
  - The requester may drop req or present a new command from the cycle after gnt.
  - The requester must hold its command stable from req assertion through gnt.
- **WRITE**
  - m_awvalid and m_wvalid assert together on state entry.
  - Each drops independently on its own valid&ready handshake; the two channels may complete in either order or the same cycle.
  - m_bready is high for the whole WRITE state.
  - On m_bvalid&m_bready: register m_bresp into resp, then go to IDLE.
- **READ**
  - m_arvalid asserts on state entry and drops on handshake.
  - m_rready is high for the whole READ state.
  - On m_rvalid&m_rready: register m_rdata/m_rresp into rdata/resp, then go to IDLE.
- **done**
  - done[i] pulses for one cycle, on the IDLE cycle after completion, for the granted requester.
  - Arbitration for the next command may occur in that same cycle.
- **Tie-offs and response handling**
  - m_awprot and m_arprot are tied to 3'b000.
  - SLVERR/DECERR responses are passed through in resp; there is no retry.
- At most one outstanding transaction; no write/read overlap.

## Timing
- Reset values:
  - State IDLE.
  - All m_*valid, m_bready, m_rready, gnt and done = 0.
  - rdata = 0, resp = 2'b00, m_* address/data/strobe = 0.
  - Pointer = 1.
- Reset asserted mid-transaction: outputs return to the reset values asynchronously and the transaction is abandoned with no done pulse. The AXI slave shares rst.
- Latency with a zero-wait slave:
  - Write: req sampled in cycle 0 → gnt plus AW/W handshake in cycle 1 → B handshake in cycle 2 → done in cycle 3.
  - Read: same, with AR in cycle 1 and R in cycle 2.
- Back-to-back throughput: one transaction per 3 cycles with a zero-wait slave.
- Valid signals never drop before their handshake (AXI rule); address and data stay stable while valid is high.
- m_bvalid or m_rvalid arriving in IDLE is ignored; it cannot occur with a compliant slave.

## Structure
- Shared package axi4l_arb_pkg:
  - state enum (IDLE/WRITE/READ)
  - AXI response constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR)
  - PROT_DEFAULT = 3'b000
- One natural sub-module, rr_arb2: the two-input round-robin picker.
  - Inputs: req[1:0], last-grant pointer.
  - Outputs: one-hot winner, updated pointer.
  - Used only in IDLE.

## Test plan
- Single write: req0 with we=1, addr 32'h44a0_0000, wdata 32'h1234_5678, wstrb 4'hF.
  - Expect gnt0 at cycle 1 and done0 at cycle 3 with resp 2'b00.
  - VIP backdoor read at 32'h44a0_0000 returns 32'h1234_5678.
- Single read: backdoor-write 32'hCAFE_F00D at 32'h44a0_0008; req1 reads that address.
  - Expect done1 with rdata 32'hCAFE_F00D and resp 2'b00.
- Contention: req0 and req1 both high from reset, each issuing 4 commands.
  - Expect grant order 0, 1, 0, 1, 0, 1, 0, 1.
  - Exactly one done per gnt, and done matches the granted requester.
- Handshake skew: slave delays m_wready by 3 cycles relative to m_awready.
  - Expect m_awvalid to drop first and m_wvalid to hold 3 more cycles.
  - Exactly one done0; memory is correct.
- Partial strobe: write 32'hAABB_CCDD with wstrb 4'b0011 over an existing 32'h1111_1111.
  - Expect memory to read back 32'h1111_CCDD.
- Reset mid-read: deassert rst while m_arvalid is high.
  - Expect all valids/gnt/done low immediately and no done pulse.
  - After release, a new read completes normally.
